// File: rtl/mb_repair_pkg.sv
// Shared definitions for the mainband lane-repair controller:
// sideband message codes, functional-lane codes and the FSM state type.
package mb_repair_pkg;

   // Sideband message codes exchanged with the link partner
   localparam logic [3:0] MSG_REPAIR_REQ = 4'hA;
   localparam logic [3:0] MSG_REPAIR_RSP = 4'hB;

   // Functional-lane codes: which part of the module is usable
   localparam logic [1:0] FL_ALL  = 2'b11;
   localparam logic [1:0] FL_LO   = 2'b01;
   localparam logic [1:0] FL_HI   = 2'b10;
   localparam logic [1:0] FL_NONE = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_RES,
      ST_EVAL,
      ST_SEND_REQ,
      ST_WAIT_RSP,
      ST_DONE,
      ST_ERROR
   } state_t;

endpackage

// File: rtl/mb_fail_scan.sv
// Combinational scan of a per-lane pass/fail vector: failure counts for the
// lower and upper halves, and the lowest failing lane indices, one per spare.
module mb_fail_scan #(
   parameter int NUM_LANES = 16,
   parameter int NUM_SPARE = 2,
   localparam int LANE_IDX_W = $clog2(NUM_LANES),
   localparam int FCNT_W = LANE_IDX_W + 1
) (
   input  logic [NUM_LANES-1:0]            i_lane_result,
   output logic [FCNT_W-1:0]               o_fail_lo,
   output logic [FCNT_W-1:0]               o_fail_hi,
   output logic [NUM_SPARE-1:0]            o_slot_valid,
   output logic [NUM_SPARE*LANE_IDX_W-1:0] o_slot_idx
);

   logic [FCNT_W-1:0]               fail_lo_c;
   logic [FCNT_W-1:0]               fail_hi_c;
   logic [NUM_SPARE-1:0]            slot_valid_c;
   logic [NUM_SPARE*LANE_IDX_W-1:0] slot_idx_c;
   logic                            placed;

   // Walk lanes in ascending order; each failing lane bumps its half's count
   // and claims the first free slot, so slots end up sorted by lane index.
   always_comb begin
      fail_lo_c    = '0;
      fail_hi_c    = '0;
      slot_valid_c = '0;
      slot_idx_c   = '0;
      placed       = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (!i_lane_result[i]) begin
            if (i < NUM_LANES / 2) begin
               fail_lo_c = fail_lo_c + FCNT_W'(1);
            end else begin
               fail_hi_c = fail_hi_c + FCNT_W'(1);
            end
            placed = 1'b0;
            for (int s = 0; s < NUM_SPARE; s++) begin
               if (!placed && !slot_valid_c[s]) begin
                  slot_valid_c[s] = 1'b1;
                  slot_idx_c[s*LANE_IDX_W +: LANE_IDX_W] = LANE_IDX_W'(i);
                  placed = 1'b1;
               end
            end
         end
      end
   end

   assign o_fail_lo    = fail_lo_c;
   assign o_fail_hi    = fail_hi_c;
   assign o_slot_valid = slot_valid_c;
   assign o_slot_idx   = slot_idx_c;

endmodule

// File: rtl/mb_lane_repair_ctrl.sv
// Mainband lane-repair controller: captures the lane pass/fail vector,
// chooses full width, spare remap, half-width degrade or error, advertises
// the choice over the sideband and waits (bounded) for the partner response.
module mb_lane_repair_ctrl
   import mb_repair_pkg::*;
#(
   parameter int NUM_LANES = 16,
   parameter int NUM_SPARE = 2,
   parameter int TIMEOUT_CYCLES = 8000,
   localparam int LANE_IDX_W = $clog2(NUM_LANES)
) (
   input  logic                            CLK,
   input  logic                            rst_n,
   input  logic                            i_start,
   input  logic                            i_spare_en,
   input  logic                            i_result_valid,
   input  logic [NUM_LANES-1:0]            i_lane_result,
   output logic                            o_msg_valid,
   output logic [3:0]                      o_msg,
   output logic [1:0]                      o_msg_info,
   input  logic                            i_msg_ack,
   input  logic                            i_rx_msg_valid,
   input  logic [3:0]                      i_rx_msg,
   output logic [1:0]                      o_functional_lanes,
   output logic [NUM_SPARE-1:0]            o_remap_valid,
   output logic [NUM_SPARE*LANE_IDX_W-1:0] o_remap_idx,
   output logic                            o_done,
   output logic                            o_train_error
);

   localparam int FCNT_W = LANE_IDX_W + 1;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                          state_q, state_d;
   logic [NUM_LANES-1:0]            vec_q, vec_d;
   logic                            spare_en_q, spare_en_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [1:0]                      fl_q, fl_d;
   logic [NUM_SPARE-1:0]            remap_valid_q, remap_valid_d;
   logic [NUM_SPARE*LANE_IDX_W-1:0] remap_idx_q, remap_idx_d;
   logic                            msg_valid_q, msg_valid_d;
   logic [3:0]                      msg_q, msg_d;
   logic [1:0]                      msg_info_q, msg_info_d;
   logic                            done_q, done_d;
   logic                            train_error_q, train_error_d;

   logic [FCNT_W-1:0]               fail_lo;
   logic [FCNT_W-1:0]               fail_hi;
   logic [FCNT_W-1:0]               fail_total;
   logic [NUM_SPARE-1:0]            scan_valid;
   logic [NUM_SPARE*LANE_IDX_W-1:0] scan_idx;
   logic [1:0]                      eval_code;
   logic [NUM_SPARE-1:0]            eval_remap_valid;
   logic [NUM_SPARE*LANE_IDX_W-1:0] eval_remap_idx;
   logic                            rsp_hit;

   mb_fail_scan #(
      .NUM_LANES (NUM_LANES),
      .NUM_SPARE (NUM_SPARE)
   ) u_scan (
      .i_lane_result (vec_q),
      .o_fail_lo     (fail_lo),
      .o_fail_hi     (fail_hi),
      .o_slot_valid  (scan_valid),
      .o_slot_idx    (scan_idx)
   );

   assign fail_total = fail_lo + fail_hi;
   assign rsp_hit    = i_rx_msg_valid && (i_rx_msg == MSG_REPAIR_RSP);

   // Repair decision from the captured vector: clean, spare remap, then the
   // surviving half, otherwise nothing usable.
   always_comb begin
      eval_code        = FL_NONE;
      eval_remap_valid = '0;
      eval_remap_idx   = '0;
      if (fail_total == '0) begin
         eval_code = FL_ALL;
      end else if (spare_en_q && (NUM_SPARE > 0) &&
                   (fail_total <= FCNT_W'(NUM_SPARE))) begin
         eval_code        = FL_ALL;
         eval_remap_valid = scan_valid;
         eval_remap_idx   = scan_idx;
      end else if (fail_hi == '0) begin
         eval_code = FL_LO;
      end else if (fail_lo == '0) begin
         eval_code = FL_HI;
      end
   end

   // Next-state, timeout counter and next values of every registered output;
   // dropping i_start from any state returns to idle with everything cleared.
   always_comb begin
      state_d       = state_q;
      vec_d         = vec_q;
      spare_en_d    = spare_en_q;
      cnt_d         = cnt_q;
      fl_d          = fl_q;
      remap_valid_d = remap_valid_q;
      remap_idx_d   = remap_idx_q;
      if (!i_start) begin
         state_d       = ST_IDLE;
         cnt_d         = '0;
         fl_d          = FL_NONE;
         remap_valid_d = '0;
         remap_idx_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
               if (i_result_valid) begin
                  vec_d      = i_lane_result;
                  spare_en_d = i_spare_en;
                  state_d    = ST_EVAL;
               end
            end
            ST_EVAL: begin
               fl_d          = eval_code;
               remap_valid_d = eval_remap_valid;
               remap_idx_d   = eval_remap_idx;
               state_d       = (eval_code == FL_NONE) ? ST_ERROR : ST_SEND_REQ;
            end
            ST_SEND_REQ: begin
               if (i_msg_ack) begin
                  state_d = ST_WAIT_RSP;
                  cnt_d   = '0;
               end
            end
            ST_WAIT_RSP: begin
               if (rsp_hit) begin
                  state_d = ST_DONE;
               end else if (cnt_q == CNT_LAST) begin
                  state_d       = ST_ERROR;
                  fl_d          = FL_NONE;
                  remap_valid_d = '0;
                  remap_idx_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            ST_ERROR: begin
               state_d = ST_ERROR;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      msg_valid_d   = (state_d == ST_SEND_REQ);
      msg_d         = (state_d == ST_SEND_REQ) ? MSG_REPAIR_REQ : 4'h0;
      msg_info_d    = (state_d == ST_SEND_REQ) ? fl_d : FL_NONE;
      done_d        = (state_d == ST_DONE);
      train_error_d = (state_d == ST_ERROR);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         vec_q         <= '0;
         spare_en_q    <= 1'b0;
         cnt_q         <= '0;
         fl_q          <= FL_NONE;
         remap_valid_q <= '0;
         remap_idx_q   <= '0;
         msg_valid_q   <= 1'b0;
         msg_q         <= 4'h0;
         msg_info_q    <= FL_NONE;
         done_q        <= 1'b0;
         train_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         vec_q         <= vec_d;
         spare_en_q    <= spare_en_d;
         cnt_q         <= cnt_d;
         fl_q          <= fl_d;
         remap_valid_q <= remap_valid_d;
         remap_idx_q   <= remap_idx_d;
         msg_valid_q   <= msg_valid_d;
         msg_q         <= msg_d;
         msg_info_q    <= msg_info_d;
         done_q        <= done_d;
         train_error_q <= train_error_d;
      end
   end

   assign o_msg_valid        = msg_valid_q;
   assign o_msg              = msg_q;
   assign o_msg_info         = msg_info_q;
   assign o_functional_lanes = fl_q;
   assign o_remap_valid      = remap_valid_q;
   assign o_remap_idx        = remap_idx_q;
   assign o_done             = done_q;
   assign o_train_error      = train_error_q;

endmodule
